// File: rtl/mem_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : mem_sequencer
//  Description : Byte-serial memory sequencer. Turns a one-cycle fetch or
//                load/store start pulse into 1, 2 or 4 little-endian RAM
//                beats and stalls the stage counter until the access is done.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_fetch,
    input  logic        start_memory,
    input  logic [31:0] pc,
    input  logic [31:0] mem_addr,
    input  logic        mem_we,
    input  logic [1:0]  mem_width,
    input  logic        mem_signed,
    input  logic [31:0] store_data,
    output logic        blocked,
    output logic [31:0] instr,
    output logic [31:0] load_data,
    output logic        misaligned,
    output logic        ram_req,
    output logic [31:0] ram_addr,
    output logic        ram_we,
    output logic [7:0]  ram_wdata,
    input  logic        ram_ack,
    input  logic [7:0]  ram_rdata
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t      state;
    logic [1:0]  beat;          // index of the byte currently on the RAM port
    logic [1:0]  last_beat;     // index of the final beat of this access
    logic [31:0] base;
    logic [31:0] wbuf;
    logic [31:0] asm_q;         // bytes collected so far
    logic [1:0]  width;
    logic        is_fetch;
    logic        is_store;
    logic        sgn;

    logic [31:0] start_addr;
    logic [1:0]  start_last;
    logic        bad_align;
    logic [4:0]  lane;
    logic [31:0] assembled;
    logic [31:0] extended;

    assign lane       = {beat, 3'b000};
    assign start_addr = start_fetch ? pc : mem_addr;

    // The stall must cover the start cycle itself, hence combinational
    assign blocked   = start_fetch | start_memory | (state != IDLE);
    assign ram_req   = (state == XFER);
    assign ram_addr  = base + {30'b0, beat};
    assign ram_we    = (state == XFER) & is_store;
    assign ram_wdata = wbuf[lane +: 8];

    // Beat count and alignment check for the request being started; fetch wins
    always_comb begin
        start_last = 2'd3;
        bad_align  = 1'b0;
        if (start_fetch) begin
            start_last = 2'd3;
            bad_align  = (pc[1:0] != 2'b00);
        end else begin
            case (mem_width)
                2'd0: begin
                    start_last = 2'd0;
                    bad_align  = 1'b0;
                end
                2'd1: begin
                    start_last = 2'd1;
                    bad_align  = mem_addr[0];
                end
                default: begin
                    start_last = 2'd3;
                    bad_align  = (mem_addr[1:0] != 2'b00);
                end
            endcase
        end
    end

    // Collected bytes with the byte arriving this cycle merged into its lane
    always_comb begin
        assembled            = asm_q;
        assembled[lane +: 8] = ram_rdata;
    end

    // Zero/sign extension of the completed load value
    always_comb begin
        case (width)
            2'd0:    extended = sgn ? {{24{assembled[7]}}, assembled[7:0]}
                                    : {24'h0, assembled[7:0]};
            2'd1:    extended = sgn ? {{16{assembled[15]}}, assembled[15:0]}
                                    : {16'h0, assembled[15:0]};
            default: extended = assembled;
        endcase
    end

    // Access sequencer: accept a start in IDLE, step beats on ack in XFER
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            beat       <= 2'd0;
            last_beat  <= 2'd0;
            base       <= 32'h0;
            wbuf       <= 32'h0;
            asm_q      <= 32'h0;
            width      <= 2'd0;
            is_fetch   <= 1'b0;
            is_store   <= 1'b0;
            sgn        <= 1'b0;
            instr      <= 32'h0;
            load_data  <= 32'h0;
            misaligned <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_fetch || start_memory) begin
                        if (bad_align) begin
                            misaligned <= 1'b1;
                        end else begin
                            misaligned <= 1'b0;
                            state      <= XFER;
                            beat       <= 2'd0;
                            last_beat  <= start_last;
                            base       <= start_addr;
                            is_fetch   <= start_fetch;
                            is_store   <= ~start_fetch & mem_we;
                            width      <= mem_width;
                            sgn        <= mem_signed;
                            wbuf       <= store_data;
                            asm_q      <= 32'h0;
                        end
                    end
                end
                XFER: begin
                    if (ram_ack) begin
                        asm_q <= assembled;
                        if (beat == last_beat) begin
                            state <= IDLE;
                            beat  <= 2'd0;
                            if (is_fetch) begin
                                instr <= assembled;
                            end else if (!is_store) begin
                                load_data <= extended;
                            end
                        end else begin
                            beat <= beat + 2'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_sequencer
//  Description : Self-checking bench for mem_sequencer with a byte RAM
//                responder and a transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_fetch = 1'b0;
    logic        start_memory = 1'b0;
    logic [31:0] pc = 32'h0;
    logic [31:0] mem_addr = 32'h0;
    logic        mem_we = 1'b0;
    logic [1:0]  mem_width = 2'd0;
    logic        mem_signed = 1'b0;
    logic [31:0] store_data = 32'h0;
    logic        blocked;
    logic [31:0] instr;
    logic [31:0] load_data;
    logic        misaligned;
    logic        ram_req;
    logic [31:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic        ram_ack;
    logic [7:0]  ram_rdata;

    mem_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .start_fetch  (start_fetch),
        .start_memory (start_memory),
        .pc           (pc),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_width    (mem_width),
        .mem_signed   (mem_signed),
        .store_data   (store_data),
        .blocked      (blocked),
        .instr        (instr),
        .load_data    (load_data),
        .misaligned   (misaligned),
        .ram_req      (ram_req),
        .ram_addr     (ram_addr),
        .ram_we       (ram_we),
        .ram_wdata    (ram_wdata),
        .ram_ack      (ram_ack),
        .ram_rdata    (ram_rdata)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_total = n_total + 1;
        if (act === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endfunction

    // ---------------- RAM responder ----------------
    logic [7:0] mem [0:4095];
    logic       alt = 1'b0;     // 1: ack low on every other request cycle
    logic       phase = 1'b0;

    assign ram_ack   = alt ? phase : 1'b1;
    assign ram_rdata = mem[ram_addr[11:0]];

    always @(posedge clk) phase <= ram_req ? ~phase : 1'b0;

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        mem[12'h100] = 8'h13; mem[12'h101] = 8'h05; mem[12'h102] = 8'h10; mem[12'h103] = 8'h00;
        mem[12'h202] = 8'h34; mem[12'h203] = 8'hF2;
        mem[12'h401] = 8'h7F;
        mem[12'h500] = 8'h93; mem[12'h501] = 8'h00; mem[12'h502] = 8'h50; mem[12'h503] = 8'h00;
        forever begin
            @(posedge clk);
            if (ram_req && ram_ack && ram_we) mem[ram_addr[11:0]] <= ram_wdata;
        end
    end

    // ---------------- Reference model ----------------
    logic        m_busy = 1'b0;
    logic [31:0] m_base = 32'h0;
    int          m_k = 0;
    int          m_n = 0;
    logic        m_fetch = 1'b0;
    logic        m_we = 1'b0;
    logic [1:0]  m_width = 2'd0;
    logic        m_sgn = 1'b0;
    logic [31:0] m_sd = 32'h0;
    logic [31:0] m_word = 32'h0;
    logic [31:0] m_instr = 32'h0;
    logic [31:0] m_load = 32'h0;
    logic        m_mis = 1'b0;

    function automatic int beats_of(input logic f, input logic [1:0] w);
        if (f) return 4;
        if (w == 2'd0) return 1;
        if (w == 2'd1) return 2;
        return 4;
    endfunction

    function automatic logic is_bad(input int n, input logic [31:0] a);
        if (n == 2) return a[0];
        if (n == 4) return a[1:0] != 2'b00;
        return 1'b0;
    endfunction

    function automatic logic [31:0] put_byte(input logic [31:0] w, input int k,
                                             input logic [7:0] b);
        logic [31:0] r;
        r = w;
        r[8*k +: 8] = b;
        return r;
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] w, input logic [1:0] wd,
                                           input logic s);
        if (wd == 2'd0) return s ? {{24{w[7]}}, w[7:0]} : {24'h0, w[7:0]};
        if (wd == 2'd1) return s ? {{16{w[15]}}, w[15:0]} : {16'h0, w[15:0]};
        return w;
    endfunction

    // Transaction-level prediction of what the sequencer should be doing
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy  <= 1'b0;
            m_k     <= 0;
            m_instr <= 32'h0;
            m_load  <= 32'h0;
            m_mis   <= 1'b0;
        end else if (!m_busy) begin
            if (start_fetch || start_memory) begin
                if (is_bad(beats_of(start_fetch, mem_width), start_fetch ? pc : mem_addr)) begin
                    m_mis <= 1'b1;
                end else begin
                    m_mis   <= 1'b0;
                    m_busy  <= 1'b1;
                    m_k     <= 0;
                    m_n     <= beats_of(start_fetch, mem_width);
                    m_base  <= start_fetch ? pc : mem_addr;
                    m_fetch <= start_fetch;
                    m_we    <= !start_fetch && mem_we;
                    m_width <= mem_width;
                    m_sgn   <= mem_signed;
                    m_sd    <= store_data;
                    m_word  <= 32'h0;
                end
            end
        end else if (ram_ack) begin
            m_word <= put_byte(m_word, m_k, mem[12'(m_base + 32'(m_k))]);
            if (m_k == m_n - 1) begin
                m_busy <= 1'b0;
                if (m_fetch)
                    m_instr <= put_byte(m_word, m_k, mem[12'(m_base + 32'(m_k))]);
                else if (!m_we)
                    m_load <= extend(put_byte(m_word, m_k, mem[12'(m_base + 32'(m_k))]),
                                     m_width, m_sgn);
            end else begin
                m_k <= m_k + 1;
            end
        end
    end

    // Every-cycle comparison of DUT outputs against the model
    int req_cnt = 0;
    always @(negedge clk) begin
        check("blocked", {31'b0, blocked}, {31'b0, start_fetch | start_memory | m_busy});
        check("ram_req", {31'b0, ram_req}, {31'b0, m_busy});
        if (m_busy) begin
            check("ram_addr", ram_addr, m_base + 32'(m_k));
            check("ram_we", {31'b0, ram_we}, {31'b0, m_we});
            if (m_we) check("ram_wdata", {24'h0, ram_wdata}, {24'h0, m_sd[8*m_k +: 8]});
        end
        check("instr", instr, m_instr);
        check("load_data", load_data, m_load);
        check("misaligned", {31'b0, misaligned}, {31'b0, m_mis});
        if (!rst) begin
            check("rst_ram_addr", ram_addr, 32'h0);
            check("rst_ram_we", {31'b0, ram_we}, 32'h0);
            check("rst_ram_wdata", {24'h0, ram_wdata}, 32'h0);
        end
        if (rst && ram_req) req_cnt <= req_cnt + 1;
    end

    // ---------------- Stimulus ----------------
    task automatic go_fetch(input logic [31:0] a);
        @(posedge clk); #1;
        start_fetch = 1'b1;
        pc = a;
    endtask

    task automatic go_mem(input logic [31:0] a, input logic we, input logic [1:0] w,
                          input logic s, input logic [31:0] d);
        @(posedge clk); #1;
        start_memory = 1'b1;
        mem_addr = a; mem_we = we; mem_width = w; mem_signed = s; store_data = d;
    endtask

    // Runs the started access to completion, reporting blocked/request cycles
    task automatic run(input int inject, output int nblk, output int nreq);
        int  r0;
        logic done;
        r0 = req_cnt;
        nblk = 0;
        done = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (!blocked) begin
                done = 1'b1;
                break;
            end
            nblk++;
            @(posedge clk); #1;
            start_fetch = 1'b0;
            start_memory = 1'b0;
            if (c + 1 == inject) begin
                start_memory = 1'b1;
                mem_addr = 32'h300; mem_we = 1'b1; mem_width = 2'd2;
                store_data = 32'h11223344;
            end
        end
        check("completion_timeout", {31'b0, done}, 32'h1);
        #1;
        nreq = req_cnt - r0;
    endtask

    int nb, nr;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_blocked", {31'b0, blocked}, 32'h0);
        check("reset_req", {31'b0, ram_req}, 32'h0);
        rst = 1'b1;

        // Fetch 0x100
        go_fetch(32'h100);
        run(0, nb, nr);
        check("fetch_blocked_cycles", nb, 5);
        check("fetch_beats", nr, 4);
        check("fetch_instr", instr, 32'h00100513);

        // Half loads, signed and unsigned
        go_mem(32'h202, 1'b0, 2'd1, 1'b1, 32'h0);
        run(0, nb, nr);
        check("lh_blocked_cycles", nb, 3);
        check("lh_signed", load_data, 32'hFFFFF234);
        go_mem(32'h202, 1'b0, 2'd1, 1'b0, 32'h0);
        run(0, nb, nr);
        check("lh_unsigned", load_data, 32'h0000F234);

        // Store word with alternating wait states
        alt = 1'b1;
        go_mem(32'h300, 1'b1, 2'd2, 1'b0, 32'hDEADBEEF);
        run(0, nb, nr);
        alt = 1'b0;
        check("sw_blocked_cycles", nb, 9);
        check("sw_req_cycles", nr, 8);
        check("sw_byte0", {24'h0, mem[12'h300]}, 32'hEF);
        check("sw_byte1", {24'h0, mem[12'h301]}, 32'hBE);
        check("sw_byte2", {24'h0, mem[12'h302]}, 32'hAD);
        check("sw_byte3", {24'h0, mem[12'h303]}, 32'hDE);
        check("sw_load_unchanged", load_data, 32'h0000F234);

        go_mem(32'h300, 1'b0, 2'd3, 1'b0, 32'h0);
        run(0, nb, nr);
        check("lw_readback", load_data, 32'hDEADBEEF);

        // Misaligned word, then an aligned byte clears the flag
        go_mem(32'h401, 1'b0, 2'd2, 1'b0, 32'h0);
        run(0, nb, nr);
        check("mis_blocked_cycles", nb, 1);
        check("mis_beats", nr, 0);
        check("mis_flag", {31'b0, misaligned}, 32'h1);
        check("mis_load_unchanged", load_data, 32'hDEADBEEF);
        go_mem(32'h203, 1'b0, 2'd0, 1'b1, 32'h0);
        run(0, nb, nr);
        check("lb_signed", load_data, 32'hFFFFFFF2);
        check("mis_cleared", {31'b0, misaligned}, 32'h0);

        // Both starts together: fetch only
        @(posedge clk); #1;
        start_fetch = 1'b1; pc = 32'h500;
        start_memory = 1'b1; mem_addr = 32'h300; mem_we = 1'b1; mem_width = 2'd2;
        store_data = 32'h11223344;
        run(0, nb, nr);
        check("both_instr", instr, 32'h00500093);
        check("both_beats", nr, 4);
        check("both_no_store", {24'h0, mem[12'h300]}, 32'hEF);

        // Start pulse during transfer is ignored
        go_fetch(32'h100);
        run(2, nb, nr);
        check("inject_beats", nr, 4);
        check("inject_instr", instr, 32'h00100513);
        check("inject_no_store", {24'h0, mem[12'h303]}, 32'hDE);

        // Reset after the second beat of a fetch
        go_fetch(32'h500);
        @(posedge clk); #1; start_fetch = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("abort_req", {31'b0, ram_req}, 32'h0);
        check("abort_addr", ram_addr, 32'h0);
        check("abort_instr", instr, 32'h0);
        check("abort_load", load_data, 32'h0);
        check("abort_blocked", {31'b0, blocked}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        go_fetch(32'h500);
        run(0, nb, nr);
        check("refetch_beats", nr, 4);
        check("refetch_instr", instr, 32'h00500093);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
